coin_collector: RTL and testbench

- Upstream stage of the per-coin animation/draw blocks; owns the `coin_alive` bit each coin instance consumes.
- Once per frame, scans NUM_COINS coin positions (world coords, as reported by the coin blocks) against Mario's world bounding box.
- On overlap: clears that coin's alive bit permanently, emits a collect pulse and advances a 2-digit BCD coin counter for the HUD/score stage.

---
 rtl/coin_collector_pkg.sv | 33 +++
 rtl/coin_collector_if.sv | 30 +++
 rtl/coin_collector_bcd.sv | 67 ++++++
 rtl/coin_collector.sv | 128 ++++++++++++
 tb/tb_coin_collector.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coin_collector_pkg.sv
// Shared types and defaults for the coin collector: FSM encoding, BCD digit type,
// hitbox defaults and the axis-aligned box overlap test.
package coin_pkg;

   typedef enum logic {
      WAIT,
      SCAN
   } coin_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [9:0] MARIO_W_DEF = 10'd16;
   localparam logic [9:0] MARIO_H_DEF = 10'd32;
   localparam logic [9:0] COIN_W_DEF  = 10'd16;
   localparam logic [9:0] COIN_H_DEF  = 10'd28;

   // Strict overlap on 11-bit sums: boxes that only touch do not overlap.
   function automatic logic box_overlap(
      input logic [9:0] ax, input logic [9:0] ay,
      input logic [9:0] aw, input logic [9:0] ah,
      input logic [9:0] bx, input logic [9:0] by,
      input logic [9:0] bw, input logic [9:0] bh
   );
      logic [10:0] a_right, a_bottom, b_right, b_bottom;
      a_right  = {1'b0, ax} + {1'b0, aw};
      a_bottom = {1'b0, ay} + {1'b0, ah};
      b_right  = {1'b0, bx} + {1'b0, bw};
      b_bottom = {1'b0, by} + {1'b0, bh};
      return ({1'b0, ax} < b_right) && ({1'b0, bx} < a_right) &&
             ({1'b0, ay} < b_bottom) && ({1'b0, by} < a_bottom);
   endfunction

endpackage

// File: rtl/coin_collector_if.sv
// Bundle between the coin collector, the per-coin blocks and the HUD/score stage.
interface coin_collector_if #(
   parameter int unsigned NUM_COINS = 4
);
   import coin_pkg::*;

   logic                      frame_clk;
   logic [9:0]                mario_x;
   logic [9:0]                mario_y;
   logic                      mario_alive;
   logic [10*NUM_COINS-1:0]   coin_x;
   logic [10*NUM_COINS-1:0]   coin_y;
   logic [NUM_COINS-1:0]      coin_alive;
   logic                      collect_pulse;
   bcd_digit_t                coin_ones;
   bcd_digit_t                coin_tens;
   logic                      busy;
   logic                      one_up;

   modport master (
      output frame_clk, mario_x, mario_y, mario_alive, coin_x, coin_y,
      input  coin_alive, collect_pulse, coin_ones, coin_tens, busy, one_up
   );

   modport slave (
      input  frame_clk, mario_x, mario_y, mario_alive, coin_x, coin_y,
      output coin_alive, collect_pulse, coin_ones, coin_tens, busy, one_up
   );

endinterface

// File: rtl/coin_collector_bcd.sv
// Two-digit BCD collected-coin counter.
// COIN_ONEUP_EN: wrap 99->00 with a one-cycle wrap pulse; otherwise saturate at 99.
module coin_bcd_counter
   import coin_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       inc,
   output bcd_digit_t ones,
   output bcd_digit_t tens,
   output logic       wrap
);

   bcd_digit_t r_ones;
   bcd_digit_t r_tens;
   logic       w_at_max;

   assign w_at_max = (r_ones == 4'd9) && (r_tens == 4'd9);

`ifdef COIN_ONEUP_EN
   logic r_wrap;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_ones <= '0;
         r_tens <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (inc) begin
            if (w_at_max) begin
               r_ones <= '0;
               r_tens <= '0;
               r_wrap <= 1'b1;
            end else if (r_ones == 4'd9) begin
               r_ones <= '0;
               r_tens <= r_tens + 4'd1;
            end else begin
               r_ones <= r_ones + 4'd1;
            end
         end
      end
   end

   assign wrap = r_wrap;
`else
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_ones <= '0;
         r_tens <= '0;
      end else if (inc && !w_at_max) begin
         if (r_ones == 4'd9) begin
            r_ones <= '0;
            r_tens <= r_tens + 4'd1;
         end else begin
            r_ones <= r_ones + 4'd1;
         end
      end
   end

   assign wrap = 1'b0;
`endif

   assign ones = r_ones;
   assign tens = r_tens;

endmodule

// File: rtl/coin_collector.sv
// Per-frame scan of coin boxes against Mario; owns coin_alive and drives the BCD count.
// COIN_ONEUP_EN (in coin_bcd_counter) selects 99->00 wrap with one_up vs saturation.
module coin_collector
   import coin_pkg::*;
#(
   parameter int unsigned NUM_COINS = 4,
   parameter logic [9:0]  MARIO_W   = MARIO_W_DEF,
   parameter logic [9:0]  MARIO_H   = MARIO_H_DEF,
   parameter logic [9:0]  COIN_W    = COIN_W_DEF,
   parameter logic [9:0]  COIN_H    = COIN_H_DEF
) (
   input  logic            Clk,
   input  logic            Reset,
   coin_collector_if.slave bus
);

   localparam int unsigned       IDX_W    = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_COINS - 1);

   coin_state_t           r_state;
   coin_state_t           w_state_next;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_fc_d;
   logic                  r_fe;
   logic [NUM_COINS-1:0]  r_coin_alive;
   logic                  r_pulse;

   logic                  w_busy;
   logic                  w_last;
   logic                  w_hit;
   logic                  w_sel_alive;
   logic [9:0]            w_cx;
   logic [9:0]            w_cy;
   bcd_digit_t            w_ones;
   bcd_digit_t            w_tens;
   logic                  w_wrap;

   // Frame strobe: fe is a registered rising edge, high for exactly one Clk.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_fc_d <= 1'b0;
         r_fe   <= 1'b0;
      end else begin
         r_fc_d <= bus.frame_clk;
         r_fe   <= bus.frame_clk & ~r_fc_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= WAIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         WAIT:    if (r_fe)   w_state_next = SCAN;
         SCAN:    if (w_last) w_state_next = WAIT;
         default: w_state_next = WAIT;
      endcase
   end

   always_comb begin
      w_cx        = '0;
      w_cy        = '0;
      w_sel_alive = 1'b0;
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_cx        = bus.coin_x[10*i +: 10];
            w_cy        = bus.coin_y[10*i +: 10];
            w_sel_alive = r_coin_alive[i];
         end
      end
   end

   always_comb begin
      w_busy = (r_state == SCAN);
      w_last = (r_idx == LAST_IDX);
      w_hit  = w_busy && bus.mario_alive && w_sel_alive &&
               box_overlap(bus.mario_x, bus.mario_y, MARIO_W, MARIO_H,
                           w_cx, w_cy, COIN_W, COIN_H);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_idx <= '0;
      end else if (r_state == WAIT || w_last) begin
         r_idx <= '0;
      end else begin
         r_idx <= r_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_coin_alive <= '1;
         r_pulse      <= 1'b0;
      end else begin
         r_pulse <= w_hit;
         for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (w_hit && (r_idx == IDX_W'(i))) begin
               r_coin_alive[i] <= 1'b0;
            end
         end
      end
   end

   // Counter is fed the unregistered hit so the count moves with collect_pulse.
   coin_bcd_counter u_bcd (
      .Clk   (Clk),
      .Reset (Reset),
      .inc   (w_hit),
      .ones  (w_ones),
      .tens  (w_tens),
      .wrap  (w_wrap)
   );

   assign bus.coin_alive    = r_coin_alive;
   assign bus.collect_pulse = r_pulse;
   assign bus.coin_ones     = w_ones;
   assign bus.coin_tens     = w_tens;
   assign bus.busy          = w_busy;
   assign bus.one_up        = w_wrap;

endmodule

// File: tb/tb_coin_collector.sv
// Scoreboard bench for coin_collector: expected collections are queued when a frame is
// launched and matched against each collect_pulse; the BCD counter is also driven standalone.
module tb_coin_collector;
   import coin_pkg::*;

   localparam int unsigned NC = 4;

   typedef struct {
      int         cyc;
      logic [3:0] alive;
      logic [3:0] ones;
      logic [3:0] tens;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   coin_collector_if #(.NUM_COINS(NC)) bus ();

   coin_collector #(
      .NUM_COINS (NC),
      .MARIO_W   (10'd16),
      .MARIO_H   (10'd32),
      .COIN_W    (10'd16),
      .COIN_H    (10'd28)
   ) dut (
      .Clk   (clk),
      .Reset (rst_n),
      .bus   (bus)
   );

   logic       cnt_inc;
   bcd_digit_t cnt_ones;
   bcd_digit_t cnt_tens;
   logic       cnt_wrap;

   coin_bcd_counter u_cnt (
      .Clk   (clk),
      .Reset (rst_n),
      .inc   (cnt_inc),
      .ones  (cnt_ones),
      .tens  (cnt_tens),
      .wrap  (cnt_wrap)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   exp_t       q[$];
   logic [3:0] ref_alive;
   int         ref_count;
   int         mx, my;
   int         cx[NC];
   int         cy[NC];

`ifdef COIN_ONEUP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   function automatic bit model_hit(int i);
      return (mx < cx[i] + 16) && (cx[i] < mx + 16) &&
             (my < cy[i] + 28) && (cy[i] < my + 32);
   endfunction

   task automatic set_mario(input int x, input int y);
      mx = x;
      my = y;
      bus.mario_x = 10'(x);
      bus.mario_y = 10'(y);
   endtask

   task automatic set_coin(input int i, input int x, input int y);
      cx[i] = x;
      cy[i] = y;
      bus.coin_x[10*i +: 10] = 10'(x);
      bus.coin_y[10*i +: 10] = 10'(y);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.frame_clk = 1'b0;
      cnt_inc       = 1'b0;
      repeat (3) @(negedge clk);
      rst_n     = 1'b1;
      ref_alive = 4'b1111;
      ref_count = 0;
      q.delete();
      @(negedge clk);
   endtask

   // drop_at > 0 clears mario_alive at that sample point, before coin (drop_at-2) is evaluated.
   task automatic run_frame(input int drop_at);
      exp_t e;
      for (int i = 0; i < NC; i++) begin
         if (bus.mario_alive && (drop_at == 0 || 2 + i < drop_at) &&
             ref_alive[i] && model_hit(i)) begin
            ref_alive[i] = 1'b0;
            if (ref_count < 99)  ref_count++;
            else if (WRAP_EN)    ref_count = 0;
            e.cyc   = 3 + i;
            e.alive = ref_alive;
            e.ones  = 4'(ref_count % 10);
            e.tens  = 4'(ref_count / 10);
            q.push_back(e);
         end
      end
      bus.frame_clk = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (drop_at != 0 && c == drop_at) bus.mario_alive = 1'b0;
         if (c == 2) begin
            n_checks++;
            if (bus.busy !== 1'b1) begin
               n_errors++;
               $display("FAIL busy_during_scan: got %b want 1", bus.busy);
            end
         end
         if (c == 6) begin
            n_checks++;
            if (bus.busy !== 1'b0) begin
               n_errors++;
               $display("FAIL busy_after_scan: got %b want 0", bus.busy);
            end
         end
         if (bus.collect_pulse === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
               n_errors++;
               $display("FAIL extra_pulse: pulse at cycle %0d, expected none", c);
            end else begin
               e = q.pop_front();
               if (c != e.cyc || bus.coin_alive !== e.alive || bus.coin_ones !== e.ones ||
                   bus.coin_tens !== e.tens || bus.one_up !== 1'b0) begin
                  n_errors++;
                  $display("FAIL pulse_match: got cyc=%0d alive=%b cnt=%0d%0d one_up=%b want cyc=%0d alive=%b cnt=%0d%0d one_up=0",
                           c, bus.coin_alive, bus.coin_tens, bus.coin_ones, bus.one_up,
                           e.cyc, e.alive, e.tens, e.ones);
               end
            end
         end
      end
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL missing_pulse: %0d expected pulses not seen, want 0", q.size());
      end
      q.delete();
      n_checks++;
      if (bus.coin_alive !== ref_alive || bus.coin_ones !== 4'(ref_count % 10) ||
          bus.coin_tens !== 4'(ref_count / 10)) begin
         n_errors++;
         $display("FAIL frame_end_state: got alive=%b cnt=%0d%0d want alive=%b cnt=%0d",
                  bus.coin_alive, bus.coin_tens, bus.coin_ones, ref_alive, ref_count);
      end
      bus.frame_clk = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.coin_alive !== 4'b1111 || bus.coin_ones !== 4'd0 || bus.coin_tens !== 4'd0 ||
             bus.busy !== 1'b0 || bus.collect_pulse !== 1'b0 || bus.one_up !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got alive=%b cnt=%0d%0d busy=%b pulse=%b one_up=%b want 1111 00 0 0 0",
                     bus.coin_alive, bus.coin_tens, bus.coin_ones, bus.busy,
                     bus.collect_pulse, bus.one_up);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.mario_alive = 1'b1;
      set_mario(100, 300);
      set_coin(0, 500, 100);
      set_coin(1, 110, 300);
      set_coin(2, 700, 50);
      set_coin(3, 300, 400);
      run_frame(0);
      run_frame(0);
   endtask

   task automatic test_edges();
      do_reset();
      bus.mario_alive = 1'b1;
      set_mario(100, 300);
      set_coin(0, 116, 300);
      set_coin(1, 100, 272);
      set_coin(2, 84, 300);
      set_coin(3, 100, 332);
      run_frame(0);
      set_coin(2, 85, 300);
      run_frame(0);
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.mario_alive = 1'b1;
      set_mario(100, 300);
      set_coin(0, 100, 300);
      set_coin(1, 105, 310);
      set_coin(2, 95, 290);
      set_coin(3, 110, 320);
      run_frame(0);
      run_frame(0);
   endtask

   task automatic test_mario_dead();
      do_reset();
      set_mario(100, 300);
      for (int i = 0; i < NC; i++) set_coin(i, 100, 300);
      bus.mario_alive = 1'b0;
      run_frame(0);
      bus.mario_alive = 1'b1;
      run_frame(4);
      bus.mario_alive = 1'b1;
      run_frame(0);
   endtask

   task automatic test_reset_mid_scan();
      exp_t e;
      do_reset();
      bus.mario_alive = 1'b1;
      set_mario(100, 300);
      for (int i = 0; i < NC; i++) set_coin(i, 100, 300);
      ref_alive[0] = 1'b0;
      ref_count    = 1;
      e.cyc = 3; e.alive = ref_alive; e.ones = 4'd1; e.tens = 4'd0;
      q.push_back(e);
      bus.frame_clk = 1'b1;
      for (int c = 1; c <= 3; c++) @(negedge clk);
      n_checks++;
      if (bus.collect_pulse !== 1'b1 || q.size() == 0) begin
         n_errors++;
         $display("FAIL midscan_first_pulse: got pulse=%b want 1", bus.collect_pulse);
      end else begin
         e = q.pop_front();
         if (bus.coin_alive !== e.alive || bus.coin_ones !== e.ones || bus.coin_tens !== e.tens) begin
            n_errors++;
            $display("FAIL midscan_first_state: got alive=%b cnt=%0d%0d want alive=%b cnt=%0d%0d",
                     bus.coin_alive, bus.coin_tens, bus.coin_ones, e.alive, e.tens, e.ones);
         end
      end
      rst_n         = 1'b0;
      bus.frame_clk = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.coin_alive !== 4'b1111 || bus.coin_ones !== 4'd0 || bus.coin_tens !== 4'd0 ||
          bus.busy !== 1'b0 || bus.collect_pulse !== 1'b0) begin
         n_errors++;
         $display("FAIL midscan_reset: got alive=%b cnt=%0d%0d busy=%b pulse=%b want 1111 00 0 0",
                  bus.coin_alive, bus.coin_tens, bus.coin_ones, bus.busy, bus.collect_pulse);
      end
      rst_n     = 1'b1;
      ref_alive = 4'b1111;
      ref_count = 0;
      q.delete();
      @(negedge clk);
   endtask

   task automatic test_counter_wrap();
      int m;
      bit w;
      do_reset();
      cnt_inc = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         m = (n <= 99) ? n : (WRAP_EN ? 0 : 99);
         w = (n == 100) && WRAP_EN;
         n_checks++;
         if (cnt_ones !== 4'(m % 10) || cnt_tens !== 4'(m / 10) || cnt_wrap !== w) begin
            n_errors++;
            $display("FAIL counter_step_%0d: got %0d%0d wrap=%b want %0d wrap=%b",
                     n, cnt_tens, cnt_ones, cnt_wrap, m, w);
         end
      end
      cnt_inc = 1'b0;
      m = WRAP_EN ? 0 : 99;
      @(negedge clk);
      n_checks++;
      if (cnt_ones !== 4'(m % 10) || cnt_tens !== 4'(m / 10) || cnt_wrap !== 1'b0) begin
         n_errors++;
         $display("FAIL counter_hold: got %0d%0d wrap=%b want %0d wrap=0",
                  cnt_tens, cnt_ones, cnt_wrap, m);
      end
   endtask

   initial begin
      bus.frame_clk   = 1'b0;
      bus.mario_alive = 1'b0;
      bus.mario_x     = '0;
      bus.mario_y     = '0;
      bus.coin_x      = '0;
      bus.coin_y      = '0;
      cnt_inc         = 1'b0;
      mx = 0;
      my = 0;
      for (int i = 0; i < NC; i++) begin
         cx[i] = 0;
         cy[i] = 0;
      end
      test_reset();
      test_single();
      test_edges();
      test_back_to_back();
      test_mario_dead();
      test_reset_mid_scan();
      test_counter_wrap();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
